// File: rtl/rob_pkg.sv
// Reorder-buffer shared types and default sizes.
// Imported by rob_entry and rob_reg_array.
package rob_pkg;

   localparam int ROB_PTRWIDTH = 5;
   localparam int ROB_BITWIDTH = 32;
   localparam int ROB_DEPTH    = 2 ** ROB_PTRWIDTH;

   typedef logic [ROB_PTRWIDTH-1:0] rob_idx_t;
   typedef logic [ROB_PTRWIDTH:0]   rob_cnt_t;

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: data, alloc and occ bits.
// Ports: clk, rst (async low), set_alloc, clr, flush, wr, wr_data -> alloc, occ, data.
module rob_entry
   import rob_pkg::*;
#(
   parameter int p_bitwidth = ROB_BITWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_alloc,
   input  logic                  clr,
   input  logic                  flush,
   input  logic                  wr,
   input  logic [p_bitwidth-1:0] wr_data,
   output logic                  alloc,
   output logic                  occ,
   output logic [p_bitwidth-1:0] data
);

   logic                  alloc_q, alloc_d;
   logic                  occ_q, occ_d;
   logic [p_bitwidth-1:0] data_q, data_d;

   // clr beats wr: a write racing the commit of this slot is lost.
   // wr checks the registered alloc, so a write racing set_alloc is lost.
   always_comb begin
      alloc_d = alloc_q;
      occ_d   = occ_q;
      data_d  = data_q;
      if (flush || clr) begin
         alloc_d = 1'b0;
         occ_d   = 1'b0;
      end else if (set_alloc) begin
         alloc_d = 1'b1;
         occ_d   = 1'b0;
      end else if (wr && alloc_q) begin
         occ_d  = 1'b1;
         data_d = wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alloc_q <= 1'b0;
         occ_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         alloc_q <= alloc_d;
         occ_q   <= occ_d;
         data_q  <= data_d;
      end
   end

   assign alloc = alloc_q;
   assign occ   = occ_q;
   assign data  = data_q;

endmodule

// File: rtl/rob_reg_array.sv
// Reorder-buffer storage: in-order alloc at tail, indexed writeback, in-order commit at head.
// Ports: alloc_val/rdy/idx, wr_en/idx/data, cmt_val/rdy/idx/data, flush, count, full, empty.
module rob_reg_array
   import rob_pkg::*;
#(
   parameter int p_ptrwidth = ROB_PTRWIDTH,
   parameter int p_bitwidth = ROB_BITWIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_val,
   output logic                  alloc_rdy,
   output logic [p_ptrwidth-1:0] alloc_idx,
   input  logic                  wr_en,
   input  logic [p_ptrwidth-1:0] wr_idx,
   input  logic [p_bitwidth-1:0] wr_data,
   output logic                  cmt_val,
   input  logic                  cmt_rdy,
   output logic [p_ptrwidth-1:0] cmt_idx,
   output logic [p_bitwidth-1:0] cmt_data,
   input  logic                  flush,
   output logic [p_ptrwidth:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int                DEPTH     = 2 ** p_ptrwidth;
   localparam logic [p_ptrwidth:0] DEPTH_CNT = DEPTH[p_ptrwidth:0];

   logic [p_ptrwidth-1:0] head_q, head_d;
   logic [p_ptrwidth-1:0] tail_q, tail_d;
   logic [p_ptrwidth:0]   count_q, count_d;

   logic [DEPTH-1:0]      alloc_vec;
   logic [DEPTH-1:0]      occ_vec;
   logic [p_bitwidth-1:0] data_arr [DEPTH];

   logic alloc_fire;
   logic cmt_fire;

   // Status comes from the registered count only; a commit does not
   // free a slot for an alloc in the same cycle.
   assign full      = (count_q == DEPTH_CNT);
   assign empty     = (count_q == '0);
   assign alloc_rdy = !full;
   assign alloc_idx = tail_q;
   assign count     = count_q;

   assign cmt_idx  = head_q;
   assign cmt_data = data_arr[head_q];
   assign cmt_val  = !empty && alloc_vec[head_q] && occ_vec[head_q];

   assign alloc_fire = alloc_val && alloc_rdy && !flush;
   assign cmt_fire   = cmt_val && cmt_rdy && !flush;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire) tail_d = tail_q + 1'b1;
         if (cmt_fire)   head_d = head_q + 1'b1;
         if (alloc_fire && !cmt_fire) count_d = count_q + 1'b1;
         else if (cmt_fire && !alloc_fire) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      localparam logic [p_ptrwidth-1:0] IDX = p_ptrwidth'(i);
      rob_entry #(
         .p_bitwidth(p_bitwidth)
      ) u_entry (
         .clk      (clk),
         .rst      (rst),
         .set_alloc(alloc_fire && (tail_q == IDX)),
         .clr      (cmt_fire && (head_q == IDX)),
         .flush    (flush),
         .wr       (wr_en && (wr_idx == IDX)),
         .wr_data  (wr_data),
         .alloc    (alloc_vec[i]),
         .occ      (occ_vec[i]),
         .data     (data_arr[i])
      );
   end

endmodule

// File: tb/tb_rob_reg_array.sv
// Directed bench for rob_reg_array at depth 4, 8-bit data.
// Each scenario task drives stimulus and checks inline.
module tb_rob_reg_array;

   logic       clk;
   logic       rst;
   logic       alloc_val;
   logic       alloc_rdy;
   logic [1:0] alloc_idx;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [7:0] wr_data;
   logic       cmt_val;
   logic       cmt_rdy;
   logic [1:0] cmt_idx;
   logic [7:0] cmt_data;
   logic       flush;
   logic [2:0] count;
   logic       full;
   logic       empty;

   int vectors;
   int miscompares;
   logic [7:0] ooo_exp [3];

   rob_reg_array #(
      .p_ptrwidth(2),
      .p_bitwidth(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .alloc_val(alloc_val),
      .alloc_rdy(alloc_rdy),
      .alloc_idx(alloc_idx),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_data  (wr_data),
      .cmt_val  (cmt_val),
      .cmt_rdy  (cmt_rdy),
      .cmt_idx  (cmt_idx),
      .cmt_data (cmt_data),
      .flush    (flush),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      alloc_val = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_data   = '0;
      cmt_rdy   = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic do_reset;
      idle();
      rst = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset;
      #1;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL por_count got %0d exp 0", count); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL por_empty got %b exp 1", empty); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL por_full got %b exp 0", full); end
      vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL por_alloc_rdy got %b exp 1", alloc_rdy); end
      vectors++; if (cmt_val !== 1'b0) begin miscompares++; $display("FAIL por_cmt_val got %b exp 0", cmt_val); end
      vectors++; if (cmt_data !== 8'h00) begin miscompares++; $display("FAIL por_cmt_data got %h exp 00", cmt_data); end
      step();
      rst = 1'b1;
      alloc_val = 1'b1;
      step();
      step();
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h05;
      step();
      wr_en = 1'b0;
      vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL pre_rst_count got %0d exp 2", count); end
      vectors++; if (cmt_val !== 1'b1) begin miscompares++; $display("FAIL pre_rst_cmt_val got %b exp 1", cmt_val); end
      alloc_val = 1'b1;
      cmt_rdy = 1'b1;
      rst = 1'b0;
      #1;
      vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL mid_rst_count got %0d exp 0", count); end
      vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL mid_rst_empty got %b exp 1", empty); end
      vectors++; if (cmt_val !== 1'b0) begin miscompares++; $display("FAIL mid_rst_cmt_val got %b exp 0", cmt_val); end
      vectors++; if (alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL mid_rst_alloc_rdy got %b exp 1", alloc_rdy); end
      vectors++; if (alloc_idx !== 2'd0) begin miscompares++; $display("FAIL mid_rst_alloc_idx got %0d exp 0", alloc_idx); end
      vectors++; if (cmt_data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_cmt_data got %h exp 00", cmt_data); end
      idle();
      rst = 1'b1;
   endtask

   task automatic test_fill_wrap;
      do_reset();
      alloc_val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++; if (alloc_idx !== 2'(i)) begin miscompares++; $display("FAIL fill_idx got %0d exp %0d", alloc_idx, i); end
         step();
      end
      vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full got %b exp 1", full); end
      vectors++; if (alloc_rdy !== 1'b0) begin miscompares++; $display("FAIL fill_alloc_rdy got %b exp 0", alloc_rdy); end
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", count); end
      step();
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_hold_count got %0d exp 4", count); end
      vectors++; if (alloc_idx !== 2'd0) begin miscompares++; $display("FAIL full_hold_idx got %0d exp 0", alloc_idx); end
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h05;
      step();
      wr_idx = 2'd1; wr_data = 8'h06;
      step();
      wr_en = 1'b0;
      vectors++; if (cmt_data !== 8'h05) begin miscompares++; $display("FAIL wrap_head0_data got %h exp 05", cmt_data); end
      cmt_rdy = 1'b1;
      alloc_val = 1'b1;
      step();
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL full_cmt_no_bypass_count got %0d exp 3", count); end
      vectors++; if (cmt_idx !== 2'd1) begin miscompares++; $display("FAIL wrap_head1_idx got %0d exp 1", cmt_idx); end
      vectors++; if (alloc_idx !== 2'd0) begin miscompares++; $display("FAIL wrap_alloc0_idx got %0d exp 0", alloc_idx); end
      step();
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL alloc_cmt_same_count got %0d exp 3", count); end
      cmt_rdy = 1'b0;
      vectors++; if (alloc_idx !== 2'd1) begin miscompares++; $display("FAIL wrap_alloc1_idx got %0d exp 1", alloc_idx); end
      step();
      alloc_val = 1'b0;
      vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL wrap_count got %0d exp 4", count); end
      vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL wrap_full got %b exp 1", full); end
      vectors++; if (cmt_val !== 1'b0) begin miscompares++; $display("FAIL wrap_head2_unwritten got %b exp 0", cmt_val); end
   endtask

   task automatic test_ooo_writeback;
      do_reset();
      ooo_exp[0] = 8'h11;
      ooo_exp[1] = 8'h22;
      ooo_exp[2] = 8'h33;
      alloc_val = 1'b1;
      step(); step(); step();
      alloc_val = 1'b0;
      vectors++; if (cmt_val !== 1'b0) begin miscompares++; $display("FAIL ooo_unwritten got %b exp 0", cmt_val); end
      wr_en = 1'b1; wr_idx = 2'd2; wr_data = 8'h33;
      step();
      vectors++; if (cmt_val !== 1'b0) begin miscompares++; $display("FAIL ooo_head_still_empty got %b exp 0", cmt_val); end
      wr_idx = 2'd0; wr_data = 8'h11;
      step();
      wr_idx = 2'd1; wr_data = 8'h22;
      vectors++; if (cmt_val !== 1'b1) begin miscompares++; $display("FAIL ooo_latency got %b exp 1", cmt_val); end
      step();
      wr_en = 1'b0;
      cmt_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (cmt_val !== 1'b1 || cmt_data !== ooo_exp[i]) begin miscompares++; $display("FAIL ooo_commit%0d got val=%b data=%h exp val=1 data=%h", i, cmt_val, cmt_data, ooo_exp[i]); end
         step();
      end
      cmt_rdy = 1'b0;
      vectors++; if (empty !== 1'b1 || cmt_val !== 1'b0) begin miscompares++; $display("FAIL ooo_drained got empty=%b val=%b exp 1 0", empty, cmt_val); end
   endtask

   task automatic test_back_pressure;
      do_reset();
      alloc_val = 1'b1;
      step();
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h5A;
      step();
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++; if (cmt_val !== 1'b1 || cmt_data !== 8'h5A || count !== 3'd1) begin miscompares++; $display("FAIL bp_hold%0d got val=%b data=%h cnt=%0d exp 1 5a 1", i, cmt_val, cmt_data, count); end
         step();
      end
      cmt_rdy = 1'b1;
      step();
      cmt_rdy = 1'b0;
      vectors++; if (count !== 3'd0 || cmt_val !== 1'b0) begin miscompares++; $display("FAIL bp_release got cnt=%0d val=%b exp 0 0", count, cmt_val); end
   endtask

   task automatic test_corner_writes;
      do_reset();
      alloc_val = 1'b1;
      step();
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'hAA;
      step();
      wr_idx = 2'd0; wr_data = 8'h10;
      step();
      vectors++; if (cmt_data !== 8'h10 || cmt_val !== 1'b1) begin miscompares++; $display("FAIL corner_head0 got val=%b data=%h exp 1 10", cmt_val, cmt_data); end
      wr_data = 8'h77;
      cmt_rdy = 1'b1;
      step();
      wr_en = 1'b0;
      cmt_rdy = 1'b0;
      vectors++; if (empty !== 1'b1 || count !== 3'd0) begin miscompares++; $display("FAIL corner_empty got empty=%b cnt=%0d exp 1 0", empty, count); end
      alloc_val = 1'b1;
      step(); step(); step();
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'h21;
      step();
      wr_idx = 2'd2; wr_data = 8'h22;
      step();
      wr_en = 1'b0;
      cmt_rdy = 1'b1;
      step(); step();
      cmt_rdy = 1'b0;
      vectors++; if (cmt_idx !== 2'd3 || cmt_val !== 1'b0) begin miscompares++; $display("FAIL corner_unalloc_wr got idx=%0d val=%b exp 3 0", cmt_idx, cmt_val); end
      vectors++; if (cmt_data !== 8'h00) begin miscompares++; $display("FAIL corner_unalloc_data got %h exp 00", cmt_data); end
      wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'h33;
      step();
      wr_en = 1'b0;
      vectors++; if (cmt_val !== 1'b1 || cmt_data !== 8'h33) begin miscompares++; $display("FAIL corner_head3 got val=%b data=%h exp 1 33", cmt_val, cmt_data); end
      cmt_rdy = 1'b1;
      step();
      cmt_rdy = 1'b0;
      vectors++; if (cmt_idx !== 2'd0 || cmt_data !== 8'h10) begin miscompares++; $display("FAIL corner_cmt_race got idx=%0d data=%h exp 0 10", cmt_idx, cmt_data); end
   endtask

   task automatic test_flush;
      do_reset();
      alloc_val = 1'b1;
      step(); step(); step();
      alloc_val = 1'b0;
      wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h44;
      step();
      wr_idx = 2'd1; wr_data = 8'h55;
      alloc_val = 1'b1;
      cmt_rdy = 1'b1;
      flush = 1'b1;
      step();
      idle();
      vectors++; if (count !== 3'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL flush_count got cnt=%0d empty=%b exp 0 1", count, empty); end
      vectors++; if (alloc_idx !== 2'd0 || cmt_idx !== 2'd0) begin miscompares++; $display("FAIL flush_ptrs got tail=%0d head=%0d exp 0 0", alloc_idx, cmt_idx); end
      vectors++; if (cmt_val !== 1'b0 || alloc_rdy !== 1'b1) begin miscompares++; $display("FAIL flush_status got val=%b rdy=%b exp 0 1", cmt_val, alloc_rdy); end
      vectors++; if (cmt_data !== 8'h44) begin miscompares++; $display("FAIL flush_data_kept got %h exp 44", cmt_data); end
      alloc_val = 1'b1;
      step();
      alloc_val = 1'b0;
      vectors++; if (count !== 3'd1 || cmt_val !== 1'b0) begin miscompares++; $display("FAIL flush_realloc got cnt=%0d val=%b exp 1 0", count, cmt_val); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      clk = 1'b0;
      rst = 1'b0;
      idle();
      test_reset();
      test_fill_wrap();
      test_ooo_writeback();
      test_back_pressure();
      test_corner_writes();
      test_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
